// File: rtl/phase_sequencer_if.sv
// Decoder/board-side signal bundle for phase_sequencer.
// The master drives run/step/E2/stp; the slave (sequencer) drives strobes, status and counters.
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic             E2;
    logic             stp;
    logic             FETCH;
    logic             EXEC1;
    logic             EXEC2;
    logic             halted;
    logic             idle;
    logic [15:0]      instr_count;
    logic [CNT_W-1:0] cyc_count;

    modport master (
        output run, step, E2, stp,
        input  FETCH, EXEC1, EXEC2, halted, idle, instr_count, cyc_count
    );

    modport slave (
        input  run, step, E2, stp,
        output FETCH, EXEC1, EXEC2, halted, idle, instr_count, cyc_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot FETCH/EXEC1/EXEC2 phase sequencer with STP halt, run/pause and debug counters.
// Optional single-step control is built when SINGLE_STEP_EN is defined.
module phase_sequencer #(
    parameter int CNT_W = 16
) (
    input logic              CLK,
    input logic              RST,
    phase_sequencer_if.slave bus
);
    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_E1    = 2;
    localparam int S_E2    = 3;
    localparam int S_HALT  = 4;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_FETCH = 5'b00010;
    localparam logic [4:0] ST_E1    = 5'b00100;
    localparam logic [4:0] ST_E2    = 5'b01000;
    localparam logic [4:0] ST_HALT  = 5'b10000;

    logic [4:0]       state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             cont;
    logic             boundary;

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic step_mode_q, step_mode_d;
    logic step_edge;

    assign step_edge = bus.step & ~step_q;
    // A stepped instruction always falls back to IDLE at its boundary.
    assign cont      = bus.run & ~step_mode_q;
`else
    logic unused_step;

    assign unused_step = bus.step;
    assign cont        = bus.run;
`endif

    assign boundary = (state_q[S_E1] & ~bus.stp & ~bus.E2) | state_q[S_E2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            cyc_q   <= '0;
`ifdef SINGLE_STEP_EN
            step_q      <= 1'b0;
            step_mode_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cyc_q   <= cyc_d;
`ifdef SINGLE_STEP_EN
            step_q      <= bus.step;
            step_mode_q <= step_mode_d;
`endif
        end
    end

    always_comb begin
        state_d = ST_IDLE;
`ifdef SINGLE_STEP_EN
        step_mode_d = step_mode_q;
`endif
        if (state_q[S_IDLE]) begin
            state_d = ST_IDLE;
`ifdef SINGLE_STEP_EN
            step_mode_d = 1'b0;
            if (bus.run) begin
                state_d = ST_FETCH;
            end else if (step_edge) begin
                state_d     = ST_FETCH;
                step_mode_d = 1'b1;
            end
`else
            if (bus.run) state_d = ST_FETCH;
`endif
        end else if (state_q[S_FETCH]) begin
            state_d = ST_E1;
        end else if (state_q[S_E1]) begin
            // STP takes priority over a second-execute request.
            if (bus.stp)     state_d = ST_HALT;
            else if (bus.E2) state_d = ST_E2;
            else if (cont)   state_d = ST_FETCH;
            else             state_d = ST_IDLE;
        end else if (state_q[S_E2]) begin
            state_d = cont ? ST_FETCH : ST_IDLE;
        end else if (state_q[S_HALT]) begin
            state_d = ST_HALT;
        end

        instr_d = boundary ? instr_q + 16'd1 : instr_q;
        cyc_d   = (state_q[S_FETCH] | state_q[S_E1] | state_q[S_E2]) ? cyc_q + 1'b1 : cyc_q;
    end

    always_comb begin
        bus.FETCH       = state_q[S_FETCH];
        bus.EXEC1       = state_q[S_E1];
        bus.EXEC2       = state_q[S_E2];
        bus.halted      = state_q[S_HALT];
        bus.idle        = state_q[S_IDLE];
        bus.instr_count = instr_q;
        bus.cyc_count   = cyc_q;
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed table-driven bench for phase_sequencer plus hand-written step and wrap sequences.
module tb_phase_sequencer;
    localparam bit [4:0] F  = 5'b10000;
    localparam bit [4:0] E1 = 5'b01000;
    localparam bit [4:0] X2 = 5'b00100;
    localparam bit [4:0] H  = 5'b00010;
    localparam bit [4:0] ID = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    phase_sequencer_if #(.CNT_W(16)) bus ();

    phase_sequencer #(.CNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        run;
        bit        e2;
        bit        stp;
        bit [4:0]  st;
        bit [15:0] ic;
        bit [15:0] cc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit rn, bit e2, bit sp, bit [4:0] st, bit [15:0] ic, bit [15:0] cc);
        vec_t v;
        v.rst = r; v.run = rn; v.e2 = e2; v.stp = sp; v.st = st; v.ic = ic; v.cc = cc;
        tbl.push_back(v);
    endfunction

    task automatic drive(bit r, bit rn, bit sp_step, bit e2, bit sp);
        rst = r; bus.run = rn; bus.step = sp_step; bus.E2 = e2; bus.stp = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, bit [4:0] st, bit [15:0] ic, bit [15:0] cc);
        bit [4:0] act;
        act = {bus.FETCH, bus.EXEC1, bus.EXEC2, bus.halted, bus.idle};
        total++;
        if (act !== st) begin
            bad++;
            $display("FAIL %s state got=%b want=%b", name, act, st);
        end
        total++;
        if (bus.instr_count !== ic) begin
            bad++;
            $display("FAIL %s instr_count got=%h want=%h", name, bus.instr_count, ic);
        end
        total++;
        if (bus.cyc_count !== cc) begin
            bad++;
            $display("FAIL %s cyc_count got=%h want=%h", name, bus.cyc_count, cc);
        end
    endtask

    initial begin
        // plain 2-cycle instructions: 10 active cycles give 5 instructions
        add(1,0,0,0, ID,0,0);
        add(0,1,0,0, F,0,0);  add(0,1,0,0, E1,0,1);
        add(0,1,0,0, F,1,2);  add(0,1,0,0, E1,1,3);
        add(0,1,0,0, F,2,4);  add(0,1,0,0, E1,2,5);
        add(0,1,0,0, F,3,6);  add(0,1,0,0, E1,3,7);
        add(0,1,0,0, F,4,8);  add(0,1,0,0, E1,4,9);
        add(0,1,0,0, F,5,10);
        // E2 in EXEC1 of 2nd instruction; stp/E2 outside EXEC1 ignored
        add(1,0,0,0, ID,0,0);
        add(0,1,0,0, F,0,0);  add(0,1,0,0, E1,0,1);
        add(0,1,0,0, F,1,2);  add(0,1,0,0, E1,1,3);
        add(0,1,1,0, X2,1,4); add(0,1,0,1, F,2,5);
        add(0,1,1,0, E1,2,6); add(0,1,0,0, F,3,7);
        // STP (with E2 also high) in EXEC1 of 3rd instruction
        add(1,0,0,0, ID,0,0);
        add(0,1,0,0, F,0,0);  add(0,1,0,0, E1,0,1);
        add(0,1,0,0, F,1,2);  add(0,1,0,0, E1,1,3);
        add(0,1,0,0, F,2,4);  add(0,1,0,0, E1,2,5);
        add(0,1,1,1, H,2,6);  add(0,0,0,0, H,2,6);
        add(0,1,0,0, H,2,6);  add(1,1,0,0, ID,0,0);
        // run dropped mid-instruction with E2, then restart, then drop in plain EXEC1
        add(0,1,0,0, F,0,0);  add(0,1,0,0, E1,0,1);
        add(0,0,1,0, X2,0,2); add(0,0,0,0, ID,1,3);
        add(0,0,0,0, ID,1,3); add(0,1,0,0, F,1,3);
        add(0,1,0,0, E1,1,4); add(0,0,0,0, ID,2,5);

        bus.run = 0; bus.step = 0; bus.E2 = 0; bus.stp = 0;
        drive(1,0,0,0,0);
        check("reset", ID, 0, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].run, 0, tbl[i].e2, tbl[i].stp);
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].ic, tbl[i].cc);
        end

        drive(1,0,0,0,0);
`ifdef SINGLE_STEP_EN
        // step edge starts one instruction; held step does not retrigger
        drive(0,0,1,0,0); check("step1_f", F, 0, 0);
        drive(0,0,1,0,0); check("step1_e1", E1, 0, 1);
        drive(0,0,1,0,0); check("step1_idle", ID, 1, 2);
        drive(0,0,1,0,0); check("step_hold", ID, 1, 2);
        drive(0,0,0,0,0);
        drive(0,0,1,0,0); check("step2_f", F, 1, 2);
        drive(0,0,0,0,0); check("step2_e1", E1, 1, 3);
        drive(0,1,0,1,0); check("step2_e2", X2, 1, 4);
        drive(0,1,0,0,0); check("step2_idle", ID, 2, 5);
        drive(0,0,1,0,0); check("step3_f", F, 2, 5);
        drive(0,0,0,0,0); check("step3_e1", E1, 2, 6);
        drive(0,0,1,0,0); check("step3_idle", ID, 3, 7);
        drive(0,0,0,0,0);
        drive(0,0,1,0,0); check("step4_f", F, 3, 7);
        drive(0,0,0,0,0); check("step4_e1", E1, 3, 8);
        drive(0,0,0,0,0); check("step4_idle", ID, 4, 9);
        // run and step edge together: continuous mode
        drive(0,1,1,0,0); check("runstep_f", F, 4, 9);
        drive(0,1,0,0,0); check("runstep_e1", E1, 4, 10);
        drive(0,1,0,0,0); check("runstep_f2", F, 5, 11);
`else
        // step is ignored in the default build
        drive(0,0,1,0,0); check("step_ign1", ID, 0, 0);
        drive(0,0,0,0,0);
        drive(0,0,1,0,0); check("step_ign2", ID, 0, 0);
`endif

        // instr_count wrap
        drive(1,0,0,0,0);
        force dut.instr_q = 16'hFFFF;
        drive(0,0,0,0,0);
        release dut.instr_q;
        drive(0,0,0,0,0); check("wrap_pre", ID, 16'hFFFF, 0);
        drive(0,1,0,0,0); check("wrap_f1", F, 16'hFFFF, 0);
        drive(0,1,0,0,0); check("wrap_e1", E1, 16'hFFFF, 1);
        drive(0,1,0,0,0); check("wrap_0", F, 16'h0000, 2);
        drive(0,1,0,0,0); check("wrap_e1b", E1, 16'h0000, 3);
        drive(0,0,0,0,0); check("wrap_1", ID, 16'h0001, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
